game_sequencer: RTL and testbench



---
 rtl/game_sequencer.sv | 143 ++++++++++++++
 tb/tb_game_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Round controller: IDLE/ARM/PLAY/HIT/DEAD/WIN phases, lives and score; `START_SYNC_EN adds a 2-flop start synchronizer.
// Outputs decode registered state one cycle after the deciding input; no backpressure, tick/eq are sampled every cycle.
module game_sequencer #(
  parameter int LIVES     = 3,
  parameter int WIN_SCORE = 9,
  parameter int ARM_TICKS = 3,
  parameter int HIT_TICKS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       eq,
  input  logic       tick,
  output logic       run,
  output logic [1:0] wordsel,
  output logic [1:0] lives,
  output logic [3:0] score
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_PLAY = 3'd2,
    S_HIT  = 3'd3,
    S_DEAD = 3'd4,
    S_WIN  = 3'd5
  } state_t;

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [3:0] WIN_END    = 4'(WIN_SCORE);
  localparam logic [3:0] ARM_END    = 4'(ARM_TICKS);
  localparam logic [3:0] HIT_END    = 4'(HIT_TICKS);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] phase_cnt;
  logic       start_src;
  logic       start_q;
  logic       start_edge;

`ifdef START_SYNC_EN
  // Both stages reset high so a button held through reset cannot fake an edge.
  logic [1:0] start_sync;
  always_ff @(posedge clk) begin
    if (reset) start_sync <= 2'b11;
    else       start_sync <= {start_sync[0], start};
  end
  assign start_src = start_sync[1];
`else
  assign start_src = start;
`endif

  always_ff @(posedge clk) begin
    if (reset) start_q <= 1'b1;
    else       start_q <= start_src;
  end

  assign start_edge = start_src & ~start_q;

  logic [3:0] cnt_inc;
  logic [3:0] score_inc;
  logic       arm_done;
  logic       hit_done;
  logic       hit_fatal;
  logic       win_reached;
  logic       new_game;

  assign cnt_inc     = phase_cnt + 4'd1;
  assign score_inc   = score + 4'd1;
  assign arm_done    = tick && (cnt_inc == ARM_END);
  assign hit_done    = tick && (cnt_inc == HIT_END);
  assign hit_fatal   = (lives <= 2'd1);
  assign win_reached = (score_inc == WIN_END);
  assign new_game    = start_edge &&
                       ((state == S_IDLE) || (state == S_DEAD) || (state == S_WIN));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; eq outranks tick in PLAY
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  state_nxt = start_edge ? S_ARM : S_IDLE;
      S_ARM:   state_nxt = arm_done ? S_PLAY : S_ARM;
      S_PLAY: begin
        if (eq)                        state_nxt = hit_fatal ? S_DEAD : S_HIT;
        else if (tick && win_reached)  state_nxt = S_WIN;
        else                           state_nxt = S_PLAY;
      end
      S_HIT:   state_nxt = hit_done ? S_PLAY : S_HIT;
      S_DEAD:  state_nxt = start_edge ? S_ARM : S_DEAD;
      S_WIN:   state_nxt = start_edge ? S_ARM : S_WIN;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode from registered state
  always_comb begin
    run     = 1'b0;
    wordsel = 2'b11;
    case (state)
      S_PLAY: begin
        run     = 1'b1;
        wordsel = 2'b00;
      end
      S_HIT, S_DEAD: wordsel = 2'b01;
      S_WIN:         wordsel = 2'b10;
      default:       wordsel = 2'b11;
    endcase
  end

  // Lives, score and phase counter
  always_ff @(posedge clk) begin
    if (reset || new_game) begin
      lives     <= LIVES_INIT;
      score     <= 4'd0;
      phase_cnt <= 4'd0;
    end else begin
      case (state)
        S_ARM: begin
          if (tick) phase_cnt <= arm_done ? 4'd0 : cnt_inc;
        end
        S_PLAY: begin
          if (eq) begin
            lives     <= hit_fatal ? 2'd0 : lives - 2'd1;
            phase_cnt <= 4'd0;
          end else if (tick) begin
            score <= score_inc;
          end
        end
        S_HIT: begin
          if (tick) phase_cnt <= hit_done ? 4'd0 : cnt_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with default parameters.
module tb_game_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b1;
  logic       eq = 1'b0;
  logic       tick = 1'b0;
  logic       run;
  logic [1:0] wordsel;
  logic [1:0] lives;
  logic [3:0] score;
  logic [8:0] obs;
  logic [8:0] exp_v;
  int checks = 0;
  int errors = 0;

  game_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .eq(eq), .tick(tick),
    .run(run), .wordsel(wordsel), .lives(lives), .score(score)
  );

  always #5 clk = ~clk;
  assign obs = {run, wordsel, lives, score};

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      step(1);
      tick = 1'b0;
    end
  endtask

  task automatic start_pulse();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1;
    step(3);
    exp_v = {1'b0, 2'b11, 2'd3, 4'd0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_held got %b exp %b", obs, exp_v); end
    reset = 1'b0;
    step(3);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_release got %b exp %b", obs, exp_v); end
    ticks(3);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL held_start_no_game got %b exp %b", obs, exp_v); end
  endtask

  task automatic test_arm();
    start = 1'b0;
    step(1);
    start_pulse();
    exp_v = {1'b0, 2'b11, 2'd3, 4'd0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL arm_entry got %b exp %b", obs, exp_v); end
    ticks(2);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL arm_two_ticks got %b exp %b", obs, exp_v); end
    ticks(1);
    exp_v = {1'b1, 2'b00, 2'd3, 4'd0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL arm_to_play got %b exp %b", obs, exp_v); end
  endtask

  task automatic test_win();
    for (int i = 1; i <= 9; i++) begin
      ticks(1);
      exp_v = (i < 9) ? {1'b1, 2'b00, 2'd3, 4'(i)} : {1'b0, 2'b10, 2'd3, 4'd9};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL score_tick_%0d got %b exp %b", i, obs, exp_v); end
    end
    ticks(2);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL win_hold got %b exp %b", obs, exp_v); end
  endtask

  task automatic test_hit();
    start_pulse();
    exp_v = {1'b0, 2'b11, 2'd3, 4'd0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL restart_from_win got %b exp %b", obs, exp_v); end
    ticks(3);
    ticks(4);
    exp_v = {1'b1, 2'b00, 2'd3, 4'd4};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL play_score4 got %b exp %b", obs, exp_v); end
    eq = 1'b1; tick = 1'b1;
    step(1);
    tick = 1'b0;
    exp_v = {1'b0, 2'b01, 2'd2, 4'd4};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL eq_beats_tick got %b exp %b", obs, exp_v); end
    step(2);
    ticks(1);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL hit_eq_held got %b exp %b", obs, exp_v); end
    tick = 1'b1;
    step(1);
    tick = 1'b0; eq = 1'b0;
    exp_v = {1'b1, 2'b00, 2'd2, 4'd4};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL hit_to_play got %b exp %b", obs, exp_v); end
  endtask

  task automatic test_dead();
    eq = 1'b1; step(1); eq = 1'b0;
    exp_v = {1'b0, 2'b01, 2'd1, 4'd4};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL second_hit got %b exp %b", obs, exp_v); end
    ticks(2);
    eq = 1'b1; step(1); eq = 1'b0;
    exp_v = {1'b0, 2'b01, 2'd0, 4'd4};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL fatal_hit got %b exp %b", obs, exp_v); end
    eq = 1'b1; ticks(2); eq = 1'b0;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL dead_hold got %b exp %b", obs, exp_v); end
    start_pulse();
    exp_v = {1'b0, 2'b11, 2'd3, 4'd0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL restart_from_dead got %b exp %b", obs, exp_v); end
  endtask

  task automatic test_reset_mid_hit();
    ticks(3);
    ticks(1);
    eq = 1'b1; step(1); eq = 1'b0;
    exp_v = {1'b0, 2'b01, 2'd2, 4'd1};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL pre_reset_hit got %b exp %b", obs, exp_v); end
    ticks(1);
    reset = 1'b1; step(1); reset = 1'b0;
    exp_v = {1'b0, 2'b11, 2'd3, 4'd0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_mid_hit got %b exp %b", obs, exp_v); end
    ticks(3);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL idle_after_reset got %b exp %b", obs, exp_v); end
  endtask

  initial begin
    test_reset();
    test_arm();
    test_win();
    test_hit();
    test_dead();
    test_reset_mid_hit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
